// File: rtl/fir_stream_arbiter.sv
// fir_stream_arbiter: shares one FIR datapath between two 16-bit AXI-Stream
// sources. Whole packets are granted round-robin; each grant's channel ID is
// queued so the FIR's output packets can be tagged with their source channel.
// Data paths are pass-through; only the grant state and tag FIFO are stored.
module fir_stream_arbiter #(
    parameter int unsigned TAG_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] s0_tdata,
    input  logic        s0_tvalid,
    input  logic        s0_tlast,
    output logic        s0_tready,
    input  logic [15:0] s1_tdata,
    input  logic        s1_tvalid,
    input  logic        s1_tlast,
    output logic        s1_tready,
    output logic [15:0] f_tdata,
    output logic        f_tvalid,
    output logic        f_tlast,
    input  logic        f_tready,
    input  logic [31:0] r_tdata,
    input  logic        r_tvalid,
    input  logic        r_tlast,
    output logic        r_tready,
    output logic [31:0] m_tdata,
    output logic        m_tvalid,
    output logic        m_tlast,
    output logic        m_tid,
    input  logic        m_tready,
    output logic [1:0]  grant,
    output logic        tag_full
);

    localparam int unsigned PTR_W = $clog2(TAG_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(TAG_DEPTH);

    typedef enum logic [1:0] {StIdle, StCh0, StCh1} state_e;

    state_e               state_q;
    logic                 rr_q;
    logic [TAG_DEPTH-1:0] tag_mem_q;
    logic [PTR_W-1:0]     wr_ptr_q;
    logic [PTR_W-1:0]     rd_ptr_q;
    logic [CNT_W-1:0]     count_q;
    logic [CNT_W-1:0]     count_d;
    logic                 any_req;
    logic                 sel_ch;
    logic                 push;
    logic                 pop;
    logic                 tag_empty;
    logic                 tag_head;

    // Arbitration choice and tag FIFO push/pop strobes
    always_comb begin
        any_req   = s0_tvalid | s1_tvalid;
        // Preferred channel wins if it requests, otherwise the other one
        sel_ch    = rr_q ? s1_tvalid : ~s0_tvalid;
        push      = (state_q == StIdle) & any_req & ~tag_full;
        tag_empty = (count_q == '0);
        tag_head  = tag_mem_q[rd_ptr_q];
        pop       = ~tag_empty & r_tvalid & m_tready & r_tlast;
        count_d   = count_q;
        if (push & ~pop) begin
            count_d = count_q + 1'b1;
        end else if (pop & ~push) begin
            count_d = count_q - 1'b1;
        end
    end

    // Packet-level grant FSM with registered grant vector
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            rr_q    <= 1'b0;
            grant   <= 2'b00;
        end else begin
            case (state_q)
                StIdle: begin
                    if (push) begin
                        if (sel_ch) begin
                            state_q <= StCh1;
                            grant   <= 2'b10;
                        end else begin
                            state_q <= StCh0;
                            grant   <= 2'b01;
                        end
                    end
                end
                StCh0: begin
                    if (s0_tvalid & f_tready & s0_tlast) begin
                        state_q <= StIdle;
                        rr_q    <= 1'b1;
                        grant   <= 2'b00;
                    end
                end
                StCh1: begin
                    if (s1_tvalid & f_tready & s1_tlast) begin
                        state_q <= StIdle;
                        rr_q    <= 1'b0;
                        grant   <= 2'b00;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    grant   <= 2'b00;
                end
            endcase
        end
    end

    // Channel-ID FIFO; pointers wrap naturally since the depth is a power of two
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tag_mem_q <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            tag_full  <= 1'b0;
        end else begin
            if (push) begin
                tag_mem_q[wr_ptr_q] <= sel_ch;
                wr_ptr_q            <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q  <= count_d;
            tag_full <= (count_d == FULL_CNT);
        end
    end

    // Route the granted channel onto the FIR input; the other channel is held off
    always_comb begin
        f_tdata   = '0;
        f_tvalid  = 1'b0;
        f_tlast   = 1'b0;
        s0_tready = 1'b0;
        s1_tready = 1'b0;
        case (state_q)
            StCh0: begin
                f_tdata   = s0_tdata;
                f_tvalid  = s0_tvalid;
                f_tlast   = s0_tlast;
                s0_tready = f_tready;
            end
            StCh1: begin
                f_tdata   = s1_tdata;
                f_tvalid  = s1_tvalid;
                f_tlast   = s1_tlast;
                s1_tready = f_tready;
            end
            default: ;
        endcase
    end

    // Pass FIR output through, tagged, only while a packet is owed
    always_comb begin
        m_tdata  = '0;
        m_tvalid = 1'b0;
        m_tlast  = 1'b0;
        m_tid    = 1'b0;
        r_tready = 1'b0;
        if (!tag_empty) begin
            m_tdata  = r_tdata;
            m_tvalid = r_tvalid;
            m_tlast  = r_tlast;
            m_tid    = tag_head;
            r_tready = m_tready;
        end
    end

endmodule

// File: doc/fir_stream_arbiter.md
# fir_stream_arbiter

Two-channel packet arbiter that time-shares the single FIR filter datapath between two 16-bit AXI-Stream sources. Whole packets (delimited by tlast) are granted round-robin to the FIR input. Each grant's channel ID is queued, and FIR output packets are tagged with the channel that produced them. Sits directly in front of and behind the FIR instance; input and output data paths are pass-through (no data storage).

## Interface

Parameters:
- TAG_DEPTH, 4, capacity of the channel-ID FIFO (packets in flight inside the FIR); power of two, ≥2

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- s0_tdata  in  16  channel 0 sample, signed
- s0_tvalid / s0_tlast  in  1 each  channel 0 valid / end of packet
- s0_tready  out  1  channel 0 ready
- s1_tdata, s1_tvalid, s1_tlast, s1_tready  same as channel 0, for channel 1
- f_tdata  out  16  to FIR s_axis_fir_tdata
- f_tvalid / f_tlast  out  1 each  to FIR input
- f_tready  in  1  from FIR s_axis_fir_tready
- r_tdata  in  32  from FIR m_axis_fir_tdata
- r_tvalid / r_tlast  in  1 each  from FIR output
- r_tready  out  1  to FIR m_axis_fir_tready
- m_tdata  out  32  tagged filtered sample
- m_tvalid / m_tlast  out  1 each
- m_tid  out  1  channel that produced the current output packet
- m_tready  in  1  downstream ready
- grant  out  2  one-hot active grant ({ch1, ch0}); 00 = idle
- tag_full  out  1  tag FIFO full (new grants stalled)

## Operation

- Arbiter FSM states: IDLE, CH0, CH1. Round-robin pointer rr (1 bit) names the preferred channel.
- IDLE: a requester is a channel with tvalid=1. If any requester exists and the tag FIFO is not full, go to CHx (preferred channel if it requests, else the other one) and push x into the tag FIFO in the same cycle. Otherwise stay in IDLE.
- CHx: combinational pass-through: f_tdata = sx_tdata, f_tvalid = sx_tvalid, f_tlast = sx_tlast, sx_tready = f_tready. The other channel's tready = 0.
- CHx exit: on a handshake (sx_tvalid & f_tready) with sx_tlast=1, go to IDLE and set rr = ~x.
- In IDLE: f_tvalid = 0, both s*_tready = 0, f_tdata/f_tlast = 0.
- Output path, tag FIFO non-empty:
  - m_tdata = r_tdata, m_tlast = r_tlast, m_tid = FIFO head.
  - m_tvalid = r_tvalid; r_tready = m_tready.
- Output path, tag FIFO empty: m_tvalid = 0, r_tready = 0, m_tid = 0.
- Pop the tag FIFO on an output handshake (r_tvalid & m_tready & non-empty) with r_tlast=1.
- Push and pop in the same cycle are allowed: occupancy is unchanged and the pointers wrap modulo TAG_DEPTH.
- Push never occurs when full, since grant is inhibited. Pop never occurs when empty.
- Single-beat packets (tlast on the first beat) are legal: a grant of one data cycle.

## Timing

- Reset values: FSM=IDLE, rr=0 (channel 0 preferred first), FIFO empty, grant=00, tag_full=0. All tvalid/tready outputs are 0, m_tid=0, and data outputs are 0.
- Grant latency: a request seen in IDLE at edge N gives grant and pass-through from edge N+1. Beats flow zero-latency through the combinational path.
- There is one idle bubble cycle between consecutive packets (CHx → IDLE → CHy).
- grant and tag_full are registered.
- The output path is purely combinational (zero latency), qualified by the registered FIFO state.
- Reset asserted mid-packet aborts the grant immediately and discards all tags. Partially delivered packets are not resumed.
- sx_tvalid dropping mid-packet keeps the grant (no timeout); the channel holds the FIR until its tlast.

## Test plan

- Single channel: ch0 sends a 4-beat packet (tdata 1,2,3,4). Expect grant=01 one cycle after tvalid, four f_* beats, and return to IDLE. The FIR output packet appears on m_* with m_tid=0, and the FIFO is empty afterward.
- Contention: both channels hold tvalid from reset with 3-beat packets. Expect grant order 01,10,01,10, a one-cycle 00 gap between them, and m_tid alternating 0,1,0,1.
- Tag full: m_tready=0 with TAG_DEPTH=4. After 4 packets, tag_full=1 and a fifth request gets no grant. Raising m_tready and completing one output packet frees a slot, and the grant follows on the next IDLE cycle.
- Backpressure: toggle f_tready every cycle during a 5-beat ch1 packet. Exactly 5 handshakes occur, s0_tready stays 0 throughout, and the FSM exits only on the tlast handshake.
- Simultaneous push/pop: with one tag queued, the output tlast handshake coincides with a new grant. Occupancy stays 1 and the head becomes the new channel ID.
- Reset mid-packet: assert reset during beat 2 of a ch0 packet. All outputs go to reset values within the same cycle (asynchronous), and after release ch0 is preferred.
